// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers used across the round datapath.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam byte_t AES_POLY = 8'h1B;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column (a0 in the top byte).
module mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [3:0][7:0] a_s;
    logic [3:0][7:0] x2_s;
    logic [3:0][7:0] x4_s;
    logic [3:0][7:0] x8_s;
    logic [3:0][7:0] m3_s;
    logic [3:0][7:0] m9_s;
    logic [3:0][7:0] m11_s;
    logic [3:0][7:0] m13_s;
    logic [3:0][7:0] m14_s;

    // Both matrices are circulant: row g uses byte g, then its three successors mod 4.
    for (genvar g = 0; g < 4; g++) begin : g_byte
        localparam logic [1:0] N1 = 2'(g + 1);
        localparam logic [1:0] N2 = 2'(g + 2);
        localparam logic [1:0] N3 = 2'(g + 3);

        assign a_s[g]   = col_in[31-8*g -: 8];
        assign x2_s[g]  = xtime(a_s[g]);
        assign x4_s[g]  = xtime(x2_s[g]);
        assign x8_s[g]  = xtime(x4_s[g]);
        assign m3_s[g]  = x2_s[g] ^ a_s[g];
        assign m9_s[g]  = a_s[g] ^ x8_s[g];
        assign m11_s[g] = a_s[g] ^ x2_s[g] ^ x8_s[g];
        assign m13_s[g] = a_s[g] ^ x4_s[g] ^ x8_s[g];
        assign m14_s[g] = x2_s[g] ^ x4_s[g] ^ x8_s[g];

        assign col_out[31-8*g -: 8] = inv
            ? (m14_s[g] ^ m11_s[N1] ^ m13_s[N2] ^ m9_s[N3])
            : (x2_s[g]  ^ m3_s[N1]  ^ a_s[N2]   ^ a_s[N3]);
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns stage: one column per clock through a shared column mixer,
// with the en/o_done level handshake used by the round controller.
module mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         i_inv,
    input  logic [127:0] i_state,
    output logic [127:0] o_state,
    output logic         o_done
);

    fsm_t   state_r;
    fsm_t   state_nxt_s;
    logic   [1:0] col_r;
    state_t work_r;
    logic   inv_r;
    logic   done_r;
    logic   done_nxt_s;
    word_t  col_sel_s;
    word_t  col_mix_s;

    mix_column_word u_mix (
        .col_in  (col_sel_s),
        .inv     (inv_r),
        .col_out (col_mix_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; en low in BUSY aborts, en must drop before a restart
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) state_nxt_s = BUSY;
                else    state_nxt_s = IDLE;
            end
            BUSY: begin
                if (!en)                state_nxt_s = IDLE;
                else if (col_r == 2'd3) state_nxt_s = DONE;
                else                    state_nxt_s = BUSY;
            end
            DONE: begin
                if (!en) state_nxt_s = IDLE;
                else     state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode, registered below so o_done has no path from en
    always_comb begin
        done_nxt_s = 1'b0;
        if (state_nxt_s == DONE) done_nxt_s = 1'b1;
        else                     done_nxt_s = 1'b0;
    end

    // Done flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_nxt_s;
        end
    end

    // Column currently being transformed
    always_comb begin
        col_sel_s = 32'h0000_0000;
        case (col_r)
            2'd0:    col_sel_s = work_r[127:96];
            2'd1:    col_sel_s = work_r[95:64];
            2'd2:    col_sel_s = work_r[63:32];
            2'd3:    col_sel_s = work_r[31:0];
            default: col_sel_s = 32'h0000_0000;
        endcase
    end

    // Working register, column counter and mode latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_r <= 128'h0;
            col_r  <= 2'd0;
            inv_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (en) begin
                        work_r <= i_state;
                        inv_r  <= i_inv;
                        col_r  <= 2'd0;
                    end else begin
                        work_r <= work_r;
                        inv_r  <= inv_r;
                        col_r  <= col_r;
                    end
                end
                BUSY: begin
                    case (col_r)
                        2'd0:    work_r[127:96] <= col_mix_s;
                        2'd1:    work_r[95:64]  <= col_mix_s;
                        2'd2:    work_r[63:32]  <= col_mix_s;
                        2'd3:    work_r[31:0]   <= col_mix_s;
                        default: work_r         <= work_r;
                    endcase
                    col_r <= col_r + 2'd1;
                end
                default: begin
                    work_r <= work_r;
                    inv_r  <= inv_r;
                    col_r  <= col_r;
                end
            endcase
        end
    end

    assign o_state = work_r;
    assign o_done  = done_r;

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequential AES MixColumns / InvMixColumns stage that consumes the 128-bit cipher state and transforms one 32-bit column per clock using GF(2^8) constant multiplication (xtime chains, polynomial 0x11B). It sits in the round datapath directly after ShiftRows (encrypt) or AddRoundKey (decrypt). It shares the `en`/`o_done` level handshake of `top_GF_Mul`, which lets the round controller drive both blocks the same way.

## Interface
- No parameters; widths are fixed by AES: 128-bit state, 32-bit column, 8-bit byte.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `en` input 1: level request. It must be held high until `o_done` is seen; dropping it aborts or acknowledges.
- `i_inv` input 1: 0 selects MixColumns, 1 selects InvMixColumns. Sampled only at start.
- `i_state` input 128: input state, FIPS-197 byte order. Byte 0 (s0,0) is `[127:120]`. Column c is `[127-32c -: 32]`. Sampled only at start.
- `o_state` output 128: result. Valid while `o_done`=1.
- `o_done` output 1: high while the result is valid and `en` is still high.

## Operation
- States: IDLE, BUSY, DONE. Column counter `col` is 2 bits.
- IDLE: if `en`=1, capture `i_state` into the working register and latch `i_inv`, set `col`=0, go to BUSY.
- BUSY, each cycle:
  - Replace column `col` of the working register with its transformed value.
  - If `en`=0: go to IDLE (abort). `o_done` stays 0 and the partial result is discarded.
  - Else if `col`=3: go to DONE.
  - Else: `col`+1.
- DONE: `o_done`=1 and `o_state` = working register (held stable). Go to IDLE when `en`=0.
  - A new operation requires `en` to fall and rise again. Holding `en` high never restarts the block.
- Forward transform, column (a0..a3):
  - b0=2a0^3a1^a2^a3
  - b1=a0^2a1^3a2^a3
  - b2=a0^a1^2a2^3a3
  - b3=3a0^a1^a2^2a3
- Inverse transform:
  - b0=14a0^11a1^13a2^9a3
  - b1=9a0^14a1^11a2^13a3
  - b2=13a0^9a1^14a2^11a3
  - b3=11a0^13a1^9a2^14a3
- Arithmetic rules:
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - 3x = xtime(x)^x.
  - 9x = x^x8, 11x = x^x2^x8, 13x = x^x4^x8, 14x = x2^x4^x8, where x2/x4/x8 are successive xtimes.
  - All results are 8 bits; there is no overflow.
- `i_state`/`i_inv` changes after the start edge have no effect.
- `o_state` outside DONE shows the working register and is "don't care" to consumers.

## Timing
- Reset (async, any state, including mid-BUSY):
  - state=IDLE, `col`=0
  - working register=128'h0, so `o_state`=0
  - `o_done`=0
  - inverse-mode latch=0
- Reset release is used synchronously. The first `en` sample occurs on the first rising edge with `rst`=0.
- Start edge E0: `en`=1 sampled in IDLE.
- Columns 0..3 are written at edges E1..E4.
- `o_done` rises after E4, giving a fixed latency of 4 cycles from the start edge. It is registered, with no combinational path from `en`.
- `o_done` falls on the first edge at which `en`=0 is sampled in DONE.
- Earliest restart: `en` low for 1 cycle, so back-to-back operations take 6 cycles each.
- `en` low at any BUSY edge: IDLE at that edge, and `o_done` never pulses.

## Structure
- Shared package `aes_pkg`:
  - `state_t` (128-bit), `word_t` (32), `byte_t` (8)
  - FSM encoding constants: IDLE/BUSY/DONE
  - constant `AES_POLY` = 8'h1B
  - `xtime` function
- Sub-module `mix_column_word`: combinational, 32-bit in, `inv` select, 32-bit out. Instantiated once and muxed by `col`.
- Top module holds only the FSM, the counter, and the working register.

## Test plan
- Forward, FIPS vectors: `i_state`=db135345_f20a225c_01010101_2d26314c, `i_inv`=0 -> `o_done` exactly 4 cycles after start, `o_state`=8e4da1bc_9fdc589d_01010101_4d7ebdf8.
- Inverse round trip: `i_state`=8e4da1bc_9fdc589d_01010101_4d7ebdf8, `i_inv`=1 -> `o_state`=db135345_f20a225c_01010101_2d26314c. Also c6c6c6c6 ×4 -> unchanged in both modes.
- Hold/ack: keep `en` high 10 cycles past done -> `o_done` and `o_state` stable, with no restart. Drop `en` -> `o_done`=0 next edge. Raise again with new data -> correct second result.
- Abort: drop `en` after E2 -> IDLE, `o_done` never asserts. Restart with d4d4d4d5 in column 0 (others 0) -> column 0 = d5d5d7d6.
- Async reset mid-BUSY: assert `rst` between edges -> `o_done`=0 and `o_state`=0 immediately, with no clock edge needed. Release and run the forward vector -> correct.
- Input isolation: change `i_state`/`i_inv` every cycle during BUSY -> result matches the values captured at E0.
